// File: rtl/legv8_multicycle_ctrl_if.sv
// Bundle between the LEGv8 multi-cycle control sequencer and its datapath / instruction source.
// Latency: none, wires only.
// Backpressure: instr_valid/instr_ready handshake; a transfer happens on valid & ready at a clk edge.
//
// Ports carried:
//   instr, instr_valid, instr_ready : instruction offer and handshake
//   Zero                            : ALU zero flag returned by the datapath
//   ALUOp, ALUSrc, Opcode_field     : ALU control
//   rd_addr_1, rd_addr_2, wr_addr   : register-file addresses
//   displacement                    : D-format immediate
//   RegWrite, MemRead, MemWrite     : one-hot datapath strobes
//   MemtoReg                        : writeback mux select
//   pc, done, illegal               : program counter and retire status
//
// master: the sequencer side.  slave: the datapath / instruction source side.
interface legv8_multicycle_ctrl_if #(
    parameter int PC_W = 64
);
    logic [31:0]     instr;
    logic            instr_valid;
    logic            instr_ready;
    logic            Zero;
    logic [1:0]      ALUOp;
    logic [10:0]     Opcode_field;
    logic [4:0]      rd_addr_1;
    logic [4:0]      rd_addr_2;
    logic [4:0]      wr_addr;
    logic [8:0]      displacement;
    logic            ALUSrc;
    logic            RegWrite;
    logic            MemRead;
    logic            MemWrite;
    logic            MemtoReg;
    logic [PC_W-1:0] pc;
    logic            done;
    logic            illegal;

    modport master (
        input  instr, instr_valid, Zero,
        output instr_ready, ALUOp, Opcode_field, rd_addr_1, rd_addr_2, wr_addr,
               displacement, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg,
               pc, done, illegal
    );

    modport slave (
        output instr, instr_valid, Zero,
        input  instr_ready, ALUOp, Opcode_field, rd_addr_1, rd_addr_2, wr_addr,
               displacement, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg,
               pc, done, illegal
    );
endinterface

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control sequencer: decodes one instruction and steps the datapath through EXEC/MEM/WB.
// Latency: handshake to done = R-type 4, LDUR 5, STUR 4, CBZ/CBNZ/B 3, illegal 2 cycles.
// Backpressure: instr_ready is high only in IDLE; instr/instr_valid are ignored while an instruction is in flight.
//
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : legv8_multicycle_ctrl_if.master (instruction handshake, Zero in; datapath controls, pc, done, illegal out)
//
// Parameters:
//   PC_W     : program counter width (>= 28 so the B offset fits)
//   RESET_PC : pc value loaded by reset
//
// Build option:
//   LEGV8_CBNZ_EN : when defined, opcode instr[31:24] = 10110101 (CBNZ) is executed like CBZ with the
//                   branch condition inverted; when undefined that opcode retires as illegal.
//
// All datapath outputs are Moore outputs decoded from the state and the instruction register, so the
// operand fields and ALU controls cannot glitch while memory and writeback consume the ALU result.
module legv8_multicycle_ctrl #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    legv8_multicycle_ctrl_if.master  bus
);

    // ------------------------------------------------------------------
    // Opcode constants
    // ------------------------------------------------------------------
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
`ifdef LEGV8_CBNZ_EN
    localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
`endif
    localparam logic [5:0]  OPC_B    = 6'b000101;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE = 3'd0,
        C_LDUR  = 3'd1,
        C_STUR  = 3'd2,
        C_CBZ   = 3'd3,
        C_CBNZ  = 3'd4,
        C_B     = 3'd5,
        C_ILL   = 3'd6
    } iclass_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [31:0]     ir_q,    ir_d;
    logic [PC_W-1:0] pc_q,    pc_d;
    logic            taken_q, taken_d;

    iclass_t         cls;
    logic            accept;
    logic [PC_W-1:0] cb_off;
    logic [PC_W-1:0] b_off;
    logic [PC_W-1:0] pc_step;

    // ------------------------------------------------------------------
    // Instruction class, decoded from the held IR
    // ------------------------------------------------------------------
    always_comb begin
        cls = C_ILL;
        if (ir_q[31:21] == OPC_ADD || ir_q[31:21] == OPC_SUB ||
            ir_q[31:21] == OPC_AND || ir_q[31:21] == OPC_ORR) begin
            cls = C_RTYPE;
        end else if (ir_q[31:21] == OPC_LDUR) begin
            cls = C_LDUR;
        end else if (ir_q[31:21] == OPC_STUR) begin
            cls = C_STUR;
        end else if (ir_q[31:24] == OPC_CBZ) begin
            cls = C_CBZ;
`ifdef LEGV8_CBNZ_EN
        end else if (ir_q[31:24] == OPC_CBNZ) begin
            cls = C_CBNZ;
`endif
        end else if (ir_q[31:26] == OPC_B) begin
            cls = C_B;
        end
    end

    // Word offsets, sign-extended to the pc width; the add below wraps silently.
    assign cb_off = {{(PC_W-21){ir_q[23]}}, ir_q[23:5], 2'b00};
    assign b_off  = {{(PC_W-28){ir_q[25]}}, ir_q[25:0], 2'b00};

    assign accept = bus.instr_valid && bus.instr_ready;

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (cls == C_ILL) ? S_DONE : S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    C_RTYPE:       state_d = S_WB;
                    C_LDUR, C_STUR: state_d = S_MEM;
                    default:       state_d = S_DONE;
                endcase
            end
            S_MEM: begin
                state_d = (cls == C_LDUR) ? S_WB : S_DONE;
            end
            S_WB: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction register, branch decision and program counter
    // ------------------------------------------------------------------
    always_comb begin
        ir_d = ir_q;
        if (state_q == S_IDLE && accept) begin
            ir_d = bus.instr;
        end
    end

    // The branch decision is captured in EXEC because that is the only cycle in
    // which the datapath's Zero flag reflects this instruction's operand.
    always_comb begin
        taken_d = taken_q;
        case (state_q)
            S_DECODE: taken_d = 1'b0;
            S_EXEC: begin
                case (cls)
                    C_CBZ:   taken_d = bus.Zero;
                    C_CBNZ:  taken_d = ~bus.Zero;
                    C_B:     taken_d = 1'b1;
                    default: taken_d = 1'b0;
                endcase
            end
            default: taken_d = taken_q;
        endcase
    end

    always_comb begin
        pc_step = {{(PC_W-3){1'b0}}, 3'd4};
        if (taken_q) begin
            pc_step = (cls == C_B) ? b_off : cb_off;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (state_q == S_DONE) begin
            pc_d = pc_q + pc_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q    <= '0;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        // Operand fields come straight from the IR, so they are stable from
        // DECODE until the next instruction is accepted.
        bus.Opcode_field = ir_q[31:21];
        bus.rd_addr_1    = ir_q[9:5];
        bus.rd_addr_2    = (cls == C_RTYPE) ? ir_q[20:16] : ir_q[4:0];
        bus.wr_addr      = ir_q[4:0];
        bus.displacement = ir_q[20:12];

        bus.ALUOp  = 2'b00;
        bus.ALUSrc = 1'b0;
        case (cls)
            C_RTYPE:        bus.ALUOp = 2'b10;
            C_CBZ, C_CBNZ:  bus.ALUOp = 2'b01;
            C_LDUR, C_STUR: bus.ALUSrc = 1'b1;
            default:        bus.ALUOp = 2'b00;
        endcase

        // Strobes are tied to a single state each, which keeps them mutually
        // exclusive and drops them as soon as reset forces IDLE.
        bus.RegWrite = (state_q == S_WB);
        bus.MemRead  = (state_q == S_MEM) && (cls == C_LDUR);
        bus.MemWrite = (state_q == S_MEM) && (cls == C_STUR);
        bus.MemtoReg = (cls == C_LDUR);

        bus.done        = (state_q == S_DONE);
        bus.illegal     = (state_q == S_DONE) && (cls == C_ILL);
        bus.instr_ready = (state_q == S_IDLE) && !reset;
        bus.pc          = pc_q;
    end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
`timescale 1ns/1ps
module tb_legv8_multicycle_ctrl;

    localparam int          PC_W   = 64;
    localparam logic [63:0] RST_PC = 64'h100;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    legv8_multicycle_ctrl_if #(.PC_W(PC_W)) bus ();

    legv8_multicycle_ctrl #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected retirement of one instruction, derived from the ISA rules.
    typedef struct {
        int          lat;
        logic        ill;
        logic [63:0] pc_before;
        logic [63:0] pc_after;
        int          rw_cyc;
        int          mr_cyc;
        int          mw_cyc;
        logic [4:0]  wa;
        logic        m2r;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [8:0]  disp;
        logic [10:0] opc;
        logic [1:0]  aluop;
        logic        alusrc;
        bit          chk_alu;
        bit          chk_ra2;
    } exp_t;

    // What the monitor saw in one busy cycle before done.
    typedef struct {
        logic [4:0]  ra1, ra2, wa;
        logic [8:0]  disp;
        logic [10:0] opc;
        logic [1:0]  aluop;
        logic        alusrc, rw, mr, mw, m2r, ill;
    } obs_t;

    exp_t        expq[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic        zsel        = 1'b0;
    bit          mon_busy    = 1'b0;
    logic [63:0] pcm;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endtask

    // Reference model: class from the opcode field, timing from the phase list,
    // next pc with plain 64-bit signed arithmetic.
    function automatic exp_t model(input logic [31:0] ins, input logic z, input logic [63:0] pc);
        exp_t   e;
        longint off;
        bit     taken, is_cbnz;
        logic [10:0] op;
        e = '{default: 0};
        op = ins[31:21];
        e.ra1 = ins[9:5];
        e.disp = ins[20:12];
        e.opc = op;
        e.pc_before = pc;
        taken = 0;
        off = 0;
        is_cbnz = 0;
`ifdef LEGV8_CBNZ_EN
        is_cbnz = (ins[31:24] == 8'hB5);
`endif
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
            e.lat = 4; e.rw_cyc = 3; e.wa = ins[4:0]; e.m2r = 0;
            e.aluop = 2'b10; e.alusrc = 0; e.chk_alu = 1; e.chk_ra2 = 1; e.ra2 = ins[20:16];
        end else if (op == OP_LDUR) begin
            e.lat = 5; e.mr_cyc = 3; e.rw_cyc = 4; e.wa = ins[4:0]; e.m2r = 1;
            e.aluop = 2'b00; e.alusrc = 1; e.chk_alu = 1;
        end else if (op == OP_STUR) begin
            e.lat = 4; e.mw_cyc = 3;
            e.aluop = 2'b00; e.alusrc = 1; e.chk_alu = 1; e.chk_ra2 = 1; e.ra2 = ins[4:0];
        end else if (ins[31:24] == 8'hB4 || is_cbnz) begin
            e.lat = 3; e.aluop = 2'b01; e.alusrc = 0; e.chk_alu = 1; e.chk_ra2 = 1; e.ra2 = ins[4:0];
            taken = is_cbnz ? !z : z;
            off = 4 * longint'($signed(ins[23:5]));
        end else if (ins[31:26] == 6'b000101) begin
            e.lat = 3;
            taken = 1;
            off = 4 * longint'($signed(ins[25:0]));
        end else begin
            e.lat = 2; e.ill = 1;
        end
        e.pc_after = taken ? pc + 64'(off) : pc + 64'd4;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int s;
        r = $urandom;
        s = $urandom_range(0, 10);
        case (s)
            0: r[31:21] = OP_ADD;
            1: r[31:21] = OP_SUB;
            2: r[31:21] = OP_AND;
            3: r[31:21] = OP_ORR;
            4: r[31:21] = OP_LDUR;
            5: r[31:21] = OP_STUR;
            6: r[31:24] = 8'hB4;
            7: r[31:24] = 8'hB5;
            8: r[31:26] = 6'b000101;
            9: r[31:21] = OP_STUR;
            default: r = $urandom;
        endcase
        return r;
    endfunction

    // Zero carries the chosen branch condition only in the second cycle after
    // the handshake (EXEC) and its complement elsewhere, so sampling in the
    // wrong cycle shows up as a wrong pc.
    initial begin : zero_drv
        int kz;
        bit hs;
        kz = 0;
        hs = 0;
        bus.Zero = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                kz = 0;
                hs = 0;
            end else begin
                if (hs) kz = 1;
                else if (kz > 0 && kz < 16) kz++;
                hs = bus.instr_ready && bus.instr_valid;
            end
            bus.Zero = (kz == 2) ? zsel : ~zsel;
        end
    end

    task automatic send(input logic [31:0] ins, input logic z, input int gap);
        int t;
        bit got;
        repeat (gap) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            bus.instr = $urandom;
        end
        t = 0;
        got = 0;
        while (!got && t < 30) begin
            @(negedge clk);
            if (bus.instr_ready) begin
                bus.instr = ins;
                bus.instr_valid = 1'b1;
                zsel = z;
                got = 1;
            end else begin
                // Garbage offers while busy must be ignored.
                bus.instr = $urandom;
                bus.instr_valid = 1'($urandom_range(0, 1));
                t++;
            end
        end
        if (!got) begin
            fail_now("ready_timeout");
            bus.instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        expq.push_back(model(ins, z, pcm));
        pcm = expq[$].pc_after;
        #1;
        bus.instr_valid = 1'b0;
        bus.instr = $urandom;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((expq.size() != 0 || mon_busy) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) fail_now("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_pc", bus.pc, RST_PC);
        chk("reset_ready", 64'(bus.instr_ready), 0);
        reset = 1'b0;
        pcm = RST_PC;
    endtask

    // Monitor: samples after the driver has settled, records busy cycles and
    // scores them against the queued expectation when done appears.
    initial begin : monitor
        obs_t        obsq[$];
        obs_t        ob;
        exp_t        e;
        int          cyc, rwc, mrc, mwc, nrw, nmr, nmw;
        bit          chk_next;
        logic [63:0] pcn;
        cyc = 0;
        chk_next = 0;
        pcn = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                mon_busy = 0;
                chk_next = 0;
                obsq.delete();
                expq.delete();
                continue;
            end
            if (chk_next) begin
                chk_next = 0;
                chk("pc_after", bus.pc, pcn);
                chk("ready_after_done", 64'(bus.instr_ready), 1);
            end
            if (mon_busy) begin
                cyc++;
                if (bus.done) begin
                    mon_busy = 0;
                    if (expq.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        e = expq.pop_front();
                        chk("latency", 64'(cyc), 64'(e.lat));
                        chk("illegal", 64'(bus.illegal), 64'(e.ill));
                        chk("pc_at_done", bus.pc, e.pc_before);
                        chk("strobes_at_done", 64'({bus.RegWrite, bus.MemRead, bus.MemWrite}), 0);
                        rwc = 0; mrc = 0; mwc = 0; nrw = 0; nmr = 0; nmw = 0;
                        foreach (obsq[i]) begin
                            ob = obsq[i];
                            if (ob.rw) begin
                                nrw++; rwc = i + 1;
                                chk("wr_addr", 64'(ob.wa), 64'(e.wa));
                                chk("MemtoReg", 64'(ob.m2r), 64'(e.m2r));
                            end
                            if (ob.mr) begin nmr++; mrc = i + 1; end
                            if (ob.mw) begin nmw++; mwc = i + 1; end
                            chk("strobe_excl", 64'(int'(ob.rw) + int'(ob.mr) + int'(ob.mw) <= 1), 1);
                            chk("illegal_early", 64'(ob.ill), 0);
                            chk("rd_addr_1", 64'(ob.ra1), 64'(e.ra1));
                            chk("displacement", 64'(ob.disp), 64'(e.disp));
                            chk("Opcode_field", 64'(ob.opc), 64'(e.opc));
                            if (e.chk_alu) begin
                                chk("ALUOp", 64'(ob.aluop), 64'(e.aluop));
                                chk("ALUSrc", 64'(ob.alusrc), 64'(e.alusrc));
                            end
                            if (e.chk_ra2) chk("rd_addr_2", 64'(ob.ra2), 64'(e.ra2));
                        end
                        chk("RegWrite_cycle", 64'(rwc), 64'(e.rw_cyc));
                        chk("RegWrite_count", 64'(nrw), 64'(e.rw_cyc != 0));
                        chk("MemRead_cycle", 64'(mrc), 64'(e.mr_cyc));
                        chk("MemRead_count", 64'(nmr), 64'(e.mr_cyc != 0));
                        chk("MemWrite_cycle", 64'(mwc), 64'(e.mw_cyc));
                        chk("MemWrite_count", 64'(nmw), 64'(e.mw_cyc != 0));
                        pcn = e.pc_after;
                        chk_next = 1;
                    end
                end else begin
                    ob.ra1 = bus.rd_addr_1;  ob.ra2 = bus.rd_addr_2;  ob.wa = bus.wr_addr;
                    ob.disp = bus.displacement;  ob.opc = bus.Opcode_field;
                    ob.aluop = bus.ALUOp;  ob.alusrc = bus.ALUSrc;
                    ob.rw = bus.RegWrite;  ob.mr = bus.MemRead;  ob.mw = bus.MemWrite;
                    ob.m2r = bus.MemtoReg;  ob.ill = bus.illegal;
                    obsq.push_back(ob);
                    if (cyc > 8) begin
                        fail_now("done_timeout");
                        mon_busy = 0;
                        if (expq.size() != 0) void'(expq.pop_front());
                    end
                end
            end else begin
                chk("idle_quiet", 64'({bus.RegWrite, bus.MemRead, bus.MemWrite, bus.done, bus.illegal}), 0);
            end
            if (!mon_busy && bus.instr_ready && bus.instr_valid) begin
                mon_busy = 1;
                cyc = 0;
                obsq.delete();
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        pcm = RST_PC;
        repeat (2) @(negedge clk);
        #4;
        chk("rst_ready", 64'(bus.instr_ready), 0);
        chk("rst_pc", bus.pc, RST_PC);
        chk("rst_outputs", 64'({bus.RegWrite, bus.MemRead, bus.MemWrite, bus.done, bus.illegal}), 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed program: ADD, LDUR, STUR, CBZ taken, B back, illegal, CBZ not taken.
        send(32'h8B020023, 1'b0, 0);
        send(32'hF8408025, 1'b0, 0);
        send(32'hF81F8025, 1'b0, 0);
        drain();
        do_reset();
        send(32'hB4000064, 1'b1, 0);
        send(32'h17FFFFFE, 1'b0, 0);
        send(32'h00000000, 1'b0, 0);
        drain();
        do_reset();
        send(32'hB4000064, 1'b0, 0);
        drain();

        // Randomized stream, mostly back-to-back with occasional idle gaps.
        for (int n = 0; n < 300; n++) begin
            send(rand_instr(), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end
        drain();

        // Reset during the MEM cycle of a store.
        send(32'hF81F8025, 1'b0, 1);
        repeat (3) @(negedge clk);
        #3;
        chk("stur_mem_before_reset", 64'(bus.MemWrite), 1);
        reset = 1'b1;
        #1;
        chk("stur_abort_memwrite", 64'(bus.MemWrite), 0);
        chk("stur_abort_pc", bus.pc, RST_PC);
        chk("stur_abort_ready", 64'(bus.instr_ready), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pcm = RST_PC;
        #1;
        chk("ready_after_release", 64'(bus.instr_ready), 1);
        send(32'h8B020023, 1'b0, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
